// File: rtl/fifo_wr_packer.sv
// Write-side packer for the async FIFO: gathers RATIO narrow beats little-endian
// into one FIFO word and presents it to the FIFO through winc/wdata, honouring wfull.
module fifo_wr_packer #(
   parameter int IN_W  = 8,
   parameter int RATIO = 4,
   parameter int CNT_W = 16
) (
   input  logic                  wclk,
   input  logic                  rrst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [IN_W-1:0]       s_data,
   input  logic                  s_last,
   input  logic                  wfull,
   output logic                  winc,
   output logic [IN_W*RATIO-1:0] wdata,
   output logic [CNT_W-1:0]      words_written
);

   localparam int WORD_W = IN_W * RATIO;
   localparam int LANE_W = $clog2(RATIO);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   logic [WORD_W-1:0] r_acc;
   logic [LANE_W-1:0] r_lane;
   logic [WORD_W-1:0] r_wdata;
   logic              r_out_valid;
   logic [CNT_W-1:0]  r_words;

   logic              w_accept;
   logic              w_complete;
   logic [WORD_W-1:0] w_word;

   // Ready depends only on registered state, so s_valid never reaches s_ready.
   assign s_ready       = !r_out_valid || !wfull;
   assign winc          = r_out_valid && !wfull;
   assign wdata         = r_wdata;
   assign words_written = r_words;

   assign w_accept   = s_valid && s_ready;
   assign w_complete = w_accept && ((r_lane == LAST_LANE) || s_last);

   // Lanes below the current one come from the accumulator, lanes above are zero.
   always_comb begin
      w_word = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (i < int'(r_lane))
            w_word[i*IN_W +: IN_W] = r_acc[i*IN_W +: IN_W];
         else if (i == int'(r_lane))
            w_word[i*IN_W +: IN_W] = s_data;
      end
   end

   always_ff @(posedge wclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_acc       <= '0;
         r_lane      <= '0;
         r_wdata     <= '0;
         r_out_valid <= 1'b0;
         r_words     <= '0;
      end else begin
         if (winc) begin
            r_out_valid <= 1'b0;
            r_words     <= r_words + CNT_W'(1);
         end
         // A completing word may load in the same cycle the previous one drains.
         if (w_accept) begin
            if (w_complete) begin
               r_wdata     <= w_word;
               r_out_valid <= 1'b1;
               r_lane      <= '0;
               r_acc       <= '0;
            end else begin
               r_acc  <= w_word;
               r_lane <= r_lane + LANE_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: directed scenarios plus random traffic, checked against
// a queue-based model of beats-to-words packing and of the FIFO write side.
module tb_fifo_wr_packer;

   localparam int IN_W  = 8;
   localparam int RATIO = 4;
   localparam int W     = IN_W * RATIO;

   logic          wclk    = 1'b0;
   logic          rrst_n  = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_last  = 1'b0;
   logic          wfull   = 1'b0;
   logic [IN_W-1:0] s_data = '0;

   logic          s_ready, winc;
   logic [W-1:0]  wdata;
   logic [15:0]   words_written;
   logic          s_ready4, winc4;
   logic [W-1:0]  wdata4;
   logic [3:0]    words_written4;

   fifo_wr_packer #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(16)) dut (
      .wclk(wclk), .rrst_n(rrst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .wfull(wfull), .winc(winc),
      .wdata(wdata), .words_written(words_written)
   );

   fifo_wr_packer #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(4)) dut4 (
      .wclk(wclk), .rrst_n(rrst_n), .s_valid(s_valid), .s_ready(s_ready4),
      .s_data(s_data), .s_last(s_last), .wfull(wfull), .winc(winc4),
      .wdata(wdata4), .words_written(words_written4)
   );

   always #5 wclk = ~wclk;

   int n_checks = 0;
   int n_errors = 0;

   logic [IN_W-1:0] cur_q[$];
   logic [W-1:0]    exp_q[$];
   int unsigned     m_count = 0;
   int              rx_words = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs, advance the model at the edge.
   task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic l, input logic f);
      logic         exp_ready;
      logic         exp_winc;
      logic [W-1:0] w;
      logic [15:0]  cnt16;
      logic [3:0]   cnt4;
      s_valid = v; s_data = d; s_last = l; wfull = f;
      #1;
      exp_ready = (exp_q.size() == 0) || !f;
      exp_winc  = (exp_q.size() != 0) && !f;
      cnt16 = m_count[15:0];
      cnt4  = m_count[3:0];
      check("s_ready", s_ready, exp_ready);
      check("winc", winc, exp_winc);
      if (exp_q.size() != 0) check("wdata", wdata, exp_q[0]);
      check("words_written", words_written, cnt16);
      check("winc_c4", winc4, exp_winc);
      check("words_written_c4", words_written4, cnt4);
      @(posedge wclk);
      if (exp_winc) begin
         void'(exp_q.pop_front());
         m_count++;
         rx_words++;
      end
      if (v && exp_ready) begin
         cur_q.push_back(d);
         if (cur_q.size() == RATIO || l) begin
            w = '0;
            foreach (cur_q[i]) w = w | (W'(cur_q[i]) << (i * IN_W));
            exp_q.push_back(w);
            cur_q.delete();
         end
      end
      @(negedge wclk);
   endtask

   task automatic do_reset(input int n);
      rrst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; wfull = 1'b0;
      cur_q.delete(); exp_q.delete(); m_count = 0;
      repeat (n) begin
         #1;
         check("rst_winc", winc, 1'b0);
         check("rst_wdata", wdata, '0);
         check("rst_s_ready", s_ready, 1'b1);
         check("rst_words", words_written, '0);
         @(negedge wclk);
      end
      rrst_n = 1'b1;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         cyc(1'b0, '0, 1'b0, 1'b0);
         guard++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   initial begin
      logic [IN_W-1:0] d;
      int sent;
      int guard;
      logic f, r;

      do_reset(2);

      // Four beats pack into one word.
      cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
      check("t1_winc", winc, 1'b1);
      check("t1_wdata", wdata, 32'h44332211);
      cyc(0, 8'h00, 0, 0);
      check("t1_words", words_written, 16'd1);
      check("t1_winc_off", winc, 1'b0);

      // Short word closed by s_last, next beat starts at lane 0.
      cyc(1, 8'hAA, 0, 0); cyc(1, 8'hBB, 1, 0);
      check("t2_wdata", wdata, 32'h0000BBAA);
      cyc(1, 8'hCC, 1, 0);
      check("t2_lane0", wdata, 32'h000000CC);
      drain();
      check("t2_words", words_written, 16'd3);

      // Word completes while the FIFO is full and stays held.
      cyc(1, 8'hAA, 0, 1); cyc(1, 8'hBB, 0, 1); cyc(1, 8'hCC, 0, 1); cyc(1, 8'hDD, 0, 1);
      repeat (10) begin
         cyc(0, 8'h00, 0, 1);
         check("t3_hold_ready", s_ready, 1'b0);
         check("t3_hold_wdata", wdata, 32'hDDCCBBAA);
      end
      cyc(0, 8'h00, 0, 0);
      check("t3_after", winc, 1'b0);
      check("t3_words", words_written, 16'd4);

      // Reset in the middle of a word.
      cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0);
      do_reset(2);
      cyc(1, 8'h10, 0, 0); cyc(1, 8'h20, 0, 0); cyc(1, 8'h30, 0, 0); cyc(1, 8'h40, 0, 0);
      check("t4_wdata", wdata, 32'h40302010);
      drain();
      check("t4_words", words_written, 16'd1);

      // 400 incrementing beats with random back-pressure.
      do_reset(1);
      rx_words = 0; d = '0; sent = 0; guard = 0;
      while (sent < 400 && guard < 5000) begin
         f = 1'($urandom_range(0, 1));
         r = (exp_q.size() == 0) || !f;
         cyc(1, d, 0, f);
         if (r) begin d++; sent++; end
         guard++;
      end
      drain();
      check("t5_rx_words", rx_words, 100);
      check("t5_words", words_written, 16'd100);

      // Fully random traffic.
      repeat (1500) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) == 0));
      end
      cyc(1, 8'h5A, 1, 0);
      drain();

      // Narrow counter wraps: 17 single-beat words.
      do_reset(1);
      for (int i = 0; i < 17; i++) cyc(1, 8'(i), 1, 0);
      drain();
      check("t6_words_c4", words_written4, 4'd1);
      check("t6_words_c16", words_written, 16'd17);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side upstream stage of the async FIFO, in the wclk domain. Accepts a narrow valid/ready byte stream, packs RATIO beats little-endian into one FIFO word, and drives the FIFO's winc/wdata while honouring wfull. Partial words are closed by s_last and zero-padded. Because the FIFO only checks winc && !wfull, no write is ever lost or duplicated.

## Interface
- IN_W, 8, input beat width in bits
- RATIO, 4, beats per FIFO word (≥2); FIFO DSIZE = IN_W*RATIO
- CNT_W, 16, width of words_written counter

- wclk  input  1  write-domain clock; all logic on posedge
- rrst_n  input  1  reset rrst_n, asynchronous, active-low; clock wclk
- s_valid  input  1  input beat valid
- s_ready  output  1  input beat accepted when s_valid && s_ready
- s_data  input  IN_W  input beat
- s_last  input  1  beat closes current word (pad remaining lanes with 0)
- wfull  input  1  FIFO full flag (registered, wclk domain)
- winc  output  1  FIFO write strobe
- wdata  output  IN_W*RATIO  FIFO write data
- words_written  output  CNT_W  count of words written, wraps

## Operation
- State: accumulator acc[IN_W*RATIO], lane counter lane[clog2(RATIO)], output register wdata with out_valid flag, counter words_written.
- s_ready = !out_valid || !wfull (output register empty or draining this cycle). Combinational from registered signals only; never from s_valid/s_last.
- winc = out_valid && !wfull. Each winc pulse is exactly one FIFO write.
- Accepted beat: data written to acc lane `lane` (lane 0 = bits [IN_W-1:0]).
  - If lane == RATIO-1 or s_last: completed word (acc with the new beat merged, lanes above `lane` forced to 0) loads wdata; out_valid <= 1; lane <= 0; acc <= 0.
  - Else lane <= lane + 1.
- Drain: when winc=1 and no word completes this cycle, out_valid <= 0. A completion and a drain in the same cycle: new word loads, out_valid stays 1 (back-to-back writes).
- Completion can only occur when s_ready=1, so the output register is never overwritten while holding an unwritten word.
- wdata held stable whenever out_valid=1 and wfull=1.
- words_written increments by 1 on each cycle winc=1; wraps 2^CNT_W-1 → 0.
- s_last on lane 0 yields word = {0…, s_data}; s_last on lane RATIO-1 behaves like a normal completion.
- s_valid=0: no state change except drain.

## Timing
- Reset values (asynchronous on rrst_n low): out_valid=0, winc=0, wdata=0, acc=0, lane=0, words_written=0; s_ready=1 (one combinational step after reset).
- Reset mid-operation: partial accumulator and any pending word are discarded; no winc during or after reset until a new word completes. The first beat after deassertion goes to lane 0.
- Latency: word-completing beat accepted at edge N → winc=1 in cycle after N (if wfull=0), write lands at edge N+1.
- Throughput: continuous s_valid with wfull=0 → s_ready stays 1, one winc per RATIO cycles (or per s_last).
- wfull=1 with out_valid=1: s_ready=0, winc=0; resumes the cycle wfull falls.
- No combinational path s_valid→s_ready or s_data→wdata.

## Test plan
- IN_W=8, RATIO=4, wfull=0; beats 0x11,0x22,0x33,0x44 → single winc pulse one cycle after 4th beat, wdata=0x44332211, words_written=1.
- Beats 0xAA, 0xBB(s_last=1) → wdata=0x0000BBAA, one winc; next beat 0xCC lands in lane 0.
- Complete a word with wfull=1 held 10 cycles → winc=0, s_ready=0, wdata stable at value; drop wfull → winc 1 cycle, s_ready=1 same cycle.
- Continuous 400 beats 0x00..0xFF incrementing, random wfull toggling → FIFO-side model receives 100 words in order, none duplicated or lost, words_written=100.
- Two beats accepted then rrst_n low 2 cycles → all outputs at reset values, no winc; subsequent 4 beats produce one correct word.
- CNT_W=4: 17 words written → words_written=1 (wrap at 15 → 0).
